// File: rtl/transfer_reg_n_if.sv
// Strobe/condition inputs and TR outputs of the LVDC transfer-condition register.
// The decoder/sequencer side drives through master; the register uses slave.
interface transfer_reg_n_if #(
    parameter int WIDTH = 9
);
    logic             V1_STB;
    logic             W6_STB;
    logic             X8_STB;
    logic             Y4_STB;
    logic             V4_STB;
    logic             RUNV;
    logic             SET_X8;
    logic             SET_Y4;
    logic             SHIFT;
    logic             SRTR;
    logic             CLTR;
    logic [WIDTH-1:0] TR;
    logic             TR_ANY;
    logic             PHASE_ERR;
    logic             TR_LOST;

    modport master (
        output V1_STB, W6_STB, X8_STB, Y4_STB, V4_STB,
        output RUNV, SET_X8, SET_Y4, SHIFT, SRTR, CLTR,
        input  TR, TR_ANY, PHASE_ERR, TR_LOST
    );

    modport slave (
        input  V1_STB, W6_STB, X8_STB, Y4_STB, V4_STB,
        input  RUNV, SET_X8, SET_Y4, SHIFT, SRTR, CLTR,
        output TR, TR_ANY, PHASE_ERR, TR_LOST
    );
endinterface

// File: rtl/transfer_reg_n.sv
// WIDTH-bit transfer-condition history: collect at X8/Y4, commit at V1, clear at W6 / MOD_N-th V4.
// Define TRANSFER_REG_STICKY_EN to enable the sticky TR_LOST overflow flag.
module transfer_reg_n #(
    parameter int WIDTH = 9,
    parameter int MOD_N = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    transfer_reg_n_if.slave  trif
);
    logic [WIDTH-1:0] r_tr;
    logic [WIDTH-1:0] w_tr_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             r_p;
    logic             w_p_nxt;
    logic [3:0]       r_cnt;
    logic [3:0]       w_cnt_nxt;
    logic             r_perr;
    logic             w_wrap;
    logic             w_v1_act;
    logic [2:0]       w_nstb;

    generate
        if (WIDTH == 1) begin : g_shift1
            assign w_shifted = r_p;
        end else begin : g_shiftn
            assign w_shifted = {r_tr[WIDTH-2:0], r_p};
        end
    endgenerate

    assign w_nstb   = 3'(trif.V1_STB) + 3'(trif.W6_STB) + 3'(trif.X8_STB) + 3'(trif.Y4_STB);
    assign w_wrap   = trif.V4_STB && (r_cnt == 4'(MOD_N - 1));
    assign w_v1_act = trif.V1_STB && !trif.W6_STB;

    always_comb begin
        w_tr_nxt  = r_tr;
        w_p_nxt   = r_p;
        w_cnt_nxt = r_cnt;
        if (trif.V4_STB)
            w_cnt_nxt = w_wrap ? 4'd0 : r_cnt + 4'd1;

        // Only the highest-priority phase strobe acts: W6 > V1 > Y4 > X8.
        if (trif.W6_STB) begin
            if (trif.CLTR)
                w_tr_nxt = '0;
            else if (trif.SRTR)
                w_tr_nxt[0] = 1'b0;
            if (w_wrap)
                w_tr_nxt[0] = 1'b0;
        end else if (trif.V1_STB) begin
            // Commit overrides a coincident modulo clear.
            if (trif.SHIFT)
                w_tr_nxt = w_shifted;
            else
                w_tr_nxt[0] = r_tr[0] | r_p;
            w_p_nxt = 1'b0;
        end else begin
            if (w_wrap)
                w_tr_nxt[0] = 1'b0;
            if (trif.Y4_STB) begin
                if (trif.SET_Y4 && trif.RUNV)
                    w_p_nxt = 1'b1;
            end else if (trif.X8_STB && trif.SET_X8) begin
                w_p_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_tr   <= '0;
            r_p    <= 1'b0;
            r_cnt  <= 4'd0;
            r_perr <= 1'b0;
        end else begin
            r_tr   <= w_tr_nxt;
            r_p    <= w_p_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_nstb > 3'd1)
                r_perr <= 1'b1;
        end
    end

`ifdef TRANSFER_REG_STICKY_EN
    logic r_lost;

    always_ff @(posedge CLK) begin
        if (RESET)
            r_lost <= 1'b0;
        else if (w_v1_act && trif.SHIFT && r_tr[WIDTH-1])
            r_lost <= 1'b1;
    end

    assign trif.TR_LOST = r_lost;
`else
    logic w_unused;
    assign w_unused     = w_v1_act;
    assign trif.TR_LOST = 1'b0;
`endif

    assign trif.TR        = r_tr;
    assign trif.TR_ANY    = |r_tr;
    assign trif.PHASE_ERR = r_perr;
endmodule

// File: tb/tb_transfer_reg_n.sv
// Scoreboard bench for transfer_reg_n: directed scenarios then random strobes vs. a bit-history model.
module tb_transfer_reg_n;
    localparam int W    = 9;
    localparam int MODN = 2;

    typedef struct {
        bit rst, v1, w6, x8, y4, v4, runv, sx8, sy4, shift, srtr, cltr;
    } stim_t;

    typedef struct {
        int unsigned tr;
        bit          any, perr, lost;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    transfer_reg_n_if #(.WIDTH(W)) trif ();

    transfer_reg_n #(.WIDTH(W), .MOD_N(MODN)) dut (
        .CLK   (clk),
        .RESET (rst),
        .trif  (trif)
    );

    exp_t        exp_q[$];
    int          nchk  = 0;
    int          npass = 0;

    // Reference state: TR kept as an integer history word.
    int unsigned m_tr   = 0;
    bit          m_p    = 0;
    int          m_v4n  = 0;
    bit          m_perr = 0;
    bit          m_lost = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned want);
        nchk++;
        if (act == want) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 1'b0};
        return s;
    endfunction

    function automatic void model(input stim_t s);
        int unsigned mask = (1 << W) - 1;
        bit          clr0;
        if (s.rst) begin
            m_tr = 0; m_p = 0; m_v4n = 0; m_perr = 0; m_lost = 0;
            return;
        end
        if (int'(s.v1) + int'(s.w6) + int'(s.x8) + int'(s.y4) > 1) m_perr = 1;
        clr0 = 0;
        if (s.v4) begin
            m_v4n = m_v4n + 1;
            if (m_v4n == MODN) begin
                m_v4n = 0;
                clr0  = 1;
            end
        end
        if (s.w6) begin
            if (s.cltr) m_tr = 0;
            else if (s.srtr) m_tr = m_tr & ~32'd1;
            if (clr0) m_tr = m_tr & ~32'd1;
        end else if (s.v1) begin
            if (s.shift) begin
`ifdef TRANSFER_REG_STICKY_EN
                if (((m_tr >> (W - 1)) & 1) == 1) m_lost = 1;
`endif
                m_tr = ((m_tr << 1) | m_p) & mask;
            end else begin
                m_tr = m_tr | m_p;
            end
            m_p = 0;
        end else begin
            if (clr0) m_tr = m_tr & ~32'd1;
            if (s.y4) begin
                if (s.sy4 && s.runv) m_p = 1;
            end else if (s.x8 && s.sx8) begin
                m_p = 1;
            end
        end
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        rst          = s.rst;
        trif.V1_STB  = s.v1;
        trif.W6_STB  = s.w6;
        trif.X8_STB  = s.x8;
        trif.Y4_STB  = s.y4;
        trif.V4_STB  = s.v4;
        trif.RUNV    = s.runv;
        trif.SET_X8  = s.sx8;
        trif.SET_Y4  = s.sy4;
        trif.SHIFT   = s.shift;
        trif.SRTR    = s.srtr;
        trif.CLTR    = s.cltr;
        model(s);
        e.tr   = m_tr;
        e.any  = (m_tr != 0);
        e.perr = m_perr;
        e.lost = m_lost;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("TR",        int'(trif.TR),        e.tr);
                chk("TR_ANY",    int'(trif.TR_ANY),    int'(e.any));
                chk("PHASE_ERR", int'(trif.PHASE_ERR), int'(e.perr));
                chk("TR_LOST",   int'(trif.TR_LOST),   int'(e.lost));
            end
        end
    end

    initial begin
        stim_t s;
        #1;
        // Reset for two clocks.
        s = idle(); s.rst = 1;
        cyc(s); cyc(s);
        cyc(idle());

        // X8 capture, V1 commit, W6 SRTR clear.
        s = idle(); s.x8 = 1; s.sx8 = 1; cyc(s);
        cyc(idle());
        s = idle(); s.v1 = 1; cyc(s);
        cyc(idle());
        s = idle(); s.w6 = 1; s.srtr = 1; cyc(s);
        cyc(idle());

        // Y4 term gated by RUNV.
        s = idle(); s.y4 = 1; s.sy4 = 1; s.runv = 0; cyc(s);
        s = idle(); s.v1 = 1; cyc(s);
        s = idle(); s.y4 = 1; s.sy4 = 1; s.runv = 1; cyc(s);
        s = idle(); s.v1 = 1; cyc(s);

        // Clear, then shift in 1,0,1 -> 0x005, then CLTR.
        s = idle(); s.w6 = 1; s.cltr = 1; cyc(s);
        s = idle(); s.x8 = 1; s.sx8 = 1; cyc(s);
        s = idle(); s.v1 = 1; s.shift = 1; cyc(s);
        s = idle(); s.v1 = 1; s.shift = 1; cyc(s);
        s = idle(); s.x8 = 1; s.sx8 = 1; cyc(s);
        s = idle(); s.v1 = 1; s.shift = 1; cyc(s);
        cyc(idle());
        s = idle(); s.w6 = 1; s.cltr = 1; cyc(s);

        // Modulo clear after second V4, then wrap coincident with V1 commit.
        s = idle(); s.x8 = 1; s.sx8 = 1; cyc(s);
        s = idle(); s.v1 = 1; cyc(s);
        s = idle(); s.v4 = 1; cyc(s);
        s = idle(); s.v4 = 1; cyc(s);
        s = idle(); s.v4 = 1; cyc(s);
        s = idle(); s.x8 = 1; s.sx8 = 1; cyc(s);
        s = idle(); s.v1 = 1; s.v4 = 1; cyc(s);
        cyc(idle());

        // Wrap coincident with W6 SRTR.
        s = idle(); s.v4 = 1; cyc(s);
        s = idle(); s.w6 = 1; s.srtr = 1; s.v4 = 1; cyc(s);

        // X8 and Y4 together: Y4 wins, X8 term ignored.
        s = idle(); s.x8 = 1; s.sx8 = 1; s.y4 = 1; s.sy4 = 0; s.runv = 1; cyc(s);
        s = idle(); s.v1 = 1; cyc(s);
        cyc(idle());

        // Ten shifts of ones overflow a 9-bit history.
        s = idle(); s.rst = 1; cyc(s);
        for (int i = 0; i < 10; i++) begin
            s = idle(); s.x8 = 1; s.sx8 = 1; cyc(s);
            s = idle(); s.v1 = 1; s.shift = 1; cyc(s);
        end
        cyc(idle());

        // Random strobes and conditions.
        for (int i = 0; i < 3000; i++) begin
            s       = idle();
            s.rst   = ($urandom_range(0, 79) == 0);
            s.v1    = ($urandom_range(0, 5) == 0);
            s.w6    = ($urandom_range(0, 9) == 0);
            s.x8    = ($urandom_range(0, 4) == 0);
            s.y4    = ($urandom_range(0, 4) == 0);
            s.v4    = ($urandom_range(0, 3) == 0);
            s.runv  = $urandom_range(0, 1);
            s.sx8   = $urandom_range(0, 1);
            s.sy4   = $urandom_range(0, 1);
            s.shift = ($urandom_range(0, 2) != 0);
            s.srtr  = $urandom_range(0, 1);
            s.cltr  = ($urandom_range(0, 3) == 0);
            cyc(s);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
